// File: rtl/prog_pkg.sv
// Shared definitions for the 8-bit move instruction format.
// The control decoder imports the same package, so the opcode layout is defined once.
package prog_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SEL_W  = 3;

    localparam logic [SEL_W-1:0] SRC_ROM  = 3'd0;
    localparam logic [SEL_W-1:0] SRC_ZERO = 3'd1;
    localparam logic [SEL_W-1:0] SRC_A    = 3'd2;
    localparam logic [SEL_W-1:0] SRC_B    = 3'd3;
    localparam logic [SEL_W-1:0] SRC_X    = 3'd4;
    localparam logic [SEL_W-1:0] SRC_RAM  = 3'd5;
    localparam logic [SEL_W-1:0] SRC_E    = 3'd6;
    localparam logic [SEL_W-1:0] SRC_S    = 3'd7;

    localparam logic [SEL_W-1:0] DST_IR   = 3'd0;
    localparam logic [SEL_W-1:0] DST_PC   = 3'd1;
    localparam logic [SEL_W-1:0] DST_A    = 3'd2;
    localparam logic [SEL_W-1:0] DST_B    = 3'd3;
    localparam logic [SEL_W-1:0] DST_X    = 3'd4;
    localparam logic [SEL_W-1:0] DST_MEM  = 3'd5;
    localparam logic [SEL_W-1:0] DST_Q    = 3'd6;
    localparam logic [SEL_W-1:0] DST_QHI  = 3'd7;

    typedef struct packed {
        logic [BYTE_W-1:0] opcode;
        logic [BYTE_W-1:0] imm;
        logic              hasImm;
    } fifoEntry_t;

    localparam int unsigned ENTRY_W = $bits(fifoEntry_t);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_IMM  = 2'd2
    } txState_t;

    // Bit 7 jump-if-carry, bits 6:4 dest, bit 3 jz/subtract, bits 2:0 source.
    function automatic logic [BYTE_W-1:0] encodeOp(
        input logic             jc,
        input logic [SEL_W-1:0] dest,
        input logic             jz,
        input logic [SEL_W-1:0] source
    );
        return {jc, dest, jz, source};
    endfunction

endpackage

// File: rtl/prog_fifo.sv
// Synchronous show-ahead FIFO with registered occupancy flags; no write-to-read bypass.
module prog_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 17
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wrEn,
    input  logic [WIDTH-1:0]           wrData,
    input  logic                       rdEn,
    output logic [WIDTH-1:0]           rdData_c,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doWr;
    logic             doRd;
    logic [CW-1:0]    countNext;

    assign doWr      = wrEn && !full;
    assign doRd      = rdEn && !empty;
    assign countNext = count + CW'(doWr) - CW'(doRd);
    assign rdData_c  = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (doWr) wrPtr <= wrPtr + AW'(1);
            if (doRd) rdPtr <= rdPtr + AW'(1);
            count <= countNext;
            full  <= (countNext == CW'(DEPTH));
            empty <= (countNext == '0);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (doWr) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/prog_stream_tx.sv
// Encodes queued move requests into instruction bytes (plus optional immediate)
// and streams them out with incrementing RAM write addresses.
module prog_stream_tx
    import prog_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter logic [7:0]  BASE  = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_source,
    input  logic [2:0]  req_dest,
    input  logic        req_jz,
    input  logic        req_jc,
    input  logic [7:0]  req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic [7:0]  out_addr,
    output logic        out_last,
    output logic [15:0] bytes_sent,
    output logic        err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fifoEntry_t         pushEntry;
    fifoEntry_t         headEntry;
    logic [ENTRY_W-1:0] headBits;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [CW-1:0]      fifoCount;
    logic [CW-1:0]      countNext;

    logic               push;
    logic               pop;
    logic               handshake;
    logic               toImm;
    logic               advance;

    txState_t           state;
    logic [7:0]         pendImm;
    logic               pendHasImm;

    assign push      = req_valid && req_ready && !fifoFull;
    assign handshake = out_valid && out_ready;
    assign toImm     = (state == ST_OP) && handshake && pendHasImm;
    // Presented byte is finished (or nothing is presented): fetch the next instruction.
    assign advance   = (state == ST_IDLE) || (handshake && !toImm);
    assign pop       = advance && !fifoEmpty;
    assign countNext = fifoCount + CW'(push) - CW'(pop);

    assign pushEntry = '{opcode: encodeOp(req_jc, req_dest, req_jz, req_source),
                         imm:    req_imm,
                         hasImm: (req_source == SRC_ROM)};
    assign headEntry = fifoEntry_t'(headBits);

    prog_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wrEn     (push),
        .wrData   (ENTRY_W'(pushEntry)),
        .rdEn     (pop),
        .rdData_c (headBits),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            out_valid  <= 1'b0;
            out_byte   <= 8'h00;
            out_addr   <= BASE;
            out_last   <= 1'b0;
            bytes_sent <= 16'h0000;
            err        <= 1'b0;
            pendImm    <= 8'h00;
            pendHasImm <= 1'b0;
        end else begin
            // Stays low for a full FIFO even when a pop happens this cycle.
            req_ready <= (countNext != CW'(DEPTH));

            if (push && req_jc && (req_dest != DST_PC)) err <= 1'b1;

            if (handshake) begin
                out_addr   <= out_addr + 8'd1;
                bytes_sent <= bytes_sent + 16'd1;
            end

            if (toImm) begin
                out_byte <= pendImm;
                out_last <= 1'b1;
                state    <= ST_IMM;
            end else if (advance) begin
                if (!fifoEmpty) begin
                    out_byte   <= headEntry.opcode;
                    out_valid  <= 1'b1;
                    out_last   <= !headEntry.hasImm;
                    pendImm    <= headEntry.imm;
                    pendHasImm <= headEntry.hasImm;
                    state      <= ST_OP;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    state     <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: doc/prog_stream_tx.md
Name: prog_stream_tx

Overview:
- Transmit side of the 8-bit instruction format consumed by the CPU control decoder.
- Accepts symbolic move requests (source, dest, jump/subtract flags, optional immediate) over a valid/ready handshake and buffers them in a small FIFO.
- Encodes each request into the instruction byte, followed by an immediate byte when the source is ROM/immediate, and streams the bytes out with a RAM write address.
- Used as the boot/debug program injector that writes programs into RAM ahead of execution.

Parameters:
- DEPTH, 4: request FIFO entries (power of two, ≥2).
- BASE, 8'h00: first output byte address after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO can accept.
- req_source  in  3  0 ROM/imm, 1 zero, 2 A, 3 B, 4 X, 5 RAM, 6 E, 7 S.
- req_dest  in  3  0 IR, 1 PC, 2 A, 3 B, 4 X, 5 MEM, 6 Q, 7 Qhi.
- req_jz  in  1  ir bit3: jump-if-zero when dest=PC, subtract otherwise.
- req_jc  in  1  ir bit7: jump-if-carry.
- req_imm  in  8  immediate; used only when req_source=0.
- out_valid  out  1  out_byte/out_addr valid.
- out_ready  in  1  sink accepts byte.
- out_byte  out  8  encoded byte.
- out_addr  out  8  destination address of out_byte.
- out_last  out  1  final byte of the current instruction.
- bytes_sent  out  16  count of accepted output bytes, wraps.
- err  out  1  sticky: a request had req_jc=1 with req_dest≠1.

Behaviour:
- Reset values: req_ready=0 during the reset cycle and 1 afterwards. out_valid=0, out_byte=0, out_addr=BASE, out_last=0, bytes_sent=0, err=0. FIFO is empty and the FSM is in IDLE.
- Reset mid-operation: discards the in-flight instruction and all queued entries. No partial byte appears after reset.
- Encoding: opcode = {req_jc, req_dest, req_jz, req_source}.
- Instruction length: 2 bytes when req_source=0, otherwise 1 byte.
- Push: a request is accepted when req_valid && req_ready. req_ready = !full.
  - When full, req_ready=0 even if a pop occurs in the same cycle.
- FIFO entry: {opcode, imm, has_imm}, 16 bits plus 1 flag.
- FSM states: IDLE, OP, IMM.
  - IDLE: if the FIFO is non-empty, pop the head, load out_byte=opcode, out_valid=1, out_last=!has_imm, then go to OP.
  - OP, on handshake (out_valid && out_ready): if has_imm, out_byte=imm, out_last=1, go to IMM. Otherwise behave as in IDLE (back-to-back pop if non-empty), or clear out_valid and go to IDLE.
  - IMM, on handshake: same as the non-imm OP exit.
- Latency: a request pushed into an empty FIFO in cycle N gives out_valid=1 in cycle N+2. Bytes stream back-to-back at one per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_byte, out_addr and out_last hold stable.
- Address and count: every output handshake increments out_addr (mod 256, wraps FF→00) and bytes_sent (mod 2^16) in the same edge. out_addr always shows the address of the byte currently presented.
- Simultaneous push and pop on a non-full FIFO: both occur; occupancy is unchanged.
- err: set on push of a request with req_jc=1 and req_dest≠1. Cleared only by reset. The request is still encoded and emitted unchanged.
- The block performs no other legality checks.

Decomposition:
- Shared package prog_pkg holds:
  - SRC_* and DST_* 3-bit constants (values listed above);
  - an encode function for the opcode layout.
- The control decoder uses the same package, so the encoding has one definition.
- One sub-module: prog_fifo (sync FIFO, parameterised DEPTH and width, full/empty flags, no bypass).

Test Plan:
- Register move: after reset, push src=2, dst=3, jz=0, jc=0 with out_ready=1 → one byte 0x32 at addr 0x00, out_last=1; bytes_sent=1.
- Immediate load: push src=0, dst=2, imm=0x5A → 0x20 at addr 0x00 (out_last=0), then 0x5A at addr 0x01 (out_last=1); bytes_sent=2.
- Conditional jumps plus subtract:
  - push (src=0, dst=1, jz=1, imm=0x10) → 0x18, 0x10;
  - push (src=0, dst=1, jc=1, imm=0x20) → 0x90, 0x20;
  - push (src=3, dst=2, jz=1) → 0x2B;
  - five bytes stream back-to-back, err=0.
- Backpressure/full:
  - hold out_ready=0 and push 5 single-byte requests with DEPTH=4 → req_ready drops after the 4th accept plus the one in OP;
  - out_byte stays stable while stalled;
  - release → all bytes emitted in order with no loss or duplication.
- Error and wrap:
  - push src=2, dst=4, jc=1 → byte 0xC2 emitted and err=1 until reset;
  - after 256 bytes, out_addr wraps to 0x00.
- Reset mid-operation: assert reset while IMM is pending → next cycle out_valid=0, out_addr=BASE, bytes_sent=0, FIFO empty, and the pending imm is never emitted.
